// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the logic sweep controller.
// States, vector count and the expected response signature of a fault-free block.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_e;

    localparam int          NUM_VEC    = 8;
    localparam logic [15:0] GOLDEN_SIG = 16'hD882;

endpackage

// File: rtl/logic_sweep_ctrl_ref.sv
// Golden combinational model of the logic block under sweep.
// The top instantiates it only when LOGIC_SWEEP_SELFCHECK_EN is defined.
module logic_ref_model (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic x_o,
    output logic y_o
);

    assign x_o = ~c_i ^ (a_i | b_i);
    assign y_o = a_i & b_i;

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Exhaustive 3-input sweep of an external logic block, capturing {x,y} per vector.
// Optional self-check against logic_ref_model is enabled by LOGIC_SWEEP_SELFCHECK_EN.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    input  logic        x,
    input  logic        y,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass,
    output logic [3:0]  mismatch_cnt
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_IDX    = 3'(NUM_VEC - 1);

    sweep_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [3:0]   settle_q, settle_d;
    logic [15:0]  result_q, result_d;
    logic         sweep_go;
    logic         vec_active;
    logic         last_vec;

    assign sweep_go   = (state_q == ST_IDLE) && start;
    assign vec_active = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign last_vec   = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (sweep_go) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    settle_d = '0;
                    result_d = '0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                // Vector idx owns result bits {2*idx+1, 2*idx} = {x, y}
                result_d[{idx_q, 1'b1}] = x;
                result_d[{idx_q, 1'b0}] = y;
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign {a, b, c} = vec_active ? idx_q : 3'b000;
    assign busy      = vec_active;
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;

`ifdef LOGIC_SWEEP_SELFCHECK_EN
    logic       x_exp, y_exp, miss;
    logic [3:0] mcnt_q, mcnt_d;
    logic       pass_q, pass_d;

    logic_ref_model u_ref (
        .a_i (a),
        .b_i (b),
        .c_i (c),
        .x_o (x_exp),
        .y_o (y_exp)
    );

    assign miss = (state_q == ST_SAMPLE) && ({x, y} != {x_exp, y_exp});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt_q <= '0;
            pass_q <= 1'b0;
        end else begin
            mcnt_q <= mcnt_d;
            pass_q <= pass_d;
        end
    end

    // The verdict is latched on the last SAMPLE so it is already valid during DONE
    always_comb begin
        mcnt_d = mcnt_q;
        pass_d = pass_q;
        if (sweep_go) begin
            mcnt_d = '0;
            pass_d = 1'b0;
        end else if (state_q == ST_SAMPLE) begin
            if (miss) mcnt_d = mcnt_q + 4'd1;
            if (last_vec) pass_d = (mcnt_d == 4'd0);
        end
    end

    assign mismatch_cnt = mcnt_q;
    assign pass         = pass_q;
`else
    assign mismatch_cnt = 4'd0;
    assign pass         = 1'b0;
`endif

endmodule
